decode_stage: RTL and testbench

- Pipelined successor to the single-cycle decoder, parametrised in register count and data width.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and reads a 2R1W register file.
- Tracks in-flight writers with a scoreboard and stalls on hazards.
- Presents registered operands and control to execute over a second valid/ready handshake.

---
 rtl/decode_pkg.sv | 36 +++
 rtl/decode_regfile.sv | 35 +++
 rtl/decode_stage.sv | 126 ++++++++++++
 tb/tb_decode_stage.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, field positions, control bundle and sign extension for decode_stage
package decode_pkg;
  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_HALT = 5'd1,
    OP_ADD  = 5'd2,
    OP_SUB  = 5'd3,
    OP_ADDI = 5'd4,
    OP_ST   = 5'd5,
    OP_BR   = 5'd6,
    OP_FFT  = 5'd7,
    OP_SET  = 5'd8,
    OP_SYN  = 5'd9,
    OP_FREQ = 5'd10
  } opcode_e;
  localparam int OP_LSB = 11;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 5;
  localparam int RT_LSB = 2;
  typedef struct packed {
    logic alu_op;
    logic reg_wr_en;
    logic mem_wr_en;
    logic branch;
    logic fft_wr_en;
    logic set_en;
    logic syn;
    logic use_imm;
    logic set_freq;
    logic halt;
  } ctrl_t;
  // Short immediates sign-extend bit 4 up to the 11-bit branch width
  function automatic logic [10:0] sext(input logic [10:0] v, input logic short_imm);
    return short_imm ? {{6{v[4]}}, v[4:0]} : v;
  endfunction
endpackage

// File: rtl/decode_regfile.sv
// decode_regfile: 2R1W register file, register 0 hard-wired to zero; DECODE_BYPASS_EN forwards write data to reads
module decode_regfile #(
  parameter int NUMREGISTERS = 8,
  parameter int DATAW = 32,
  localparam int IW = (NUMREGISTERS > 1) ? $clog2(NUMREGISTERS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [DATAW-1:0] wdata_i,
  input  logic [IW-1:0]    raddr0_i,
  input  logic [IW-1:0]    raddr1_i,
  output logic [DATAW-1:0] rdata0_o,
  output logic [DATAW-1:0] rdata1_o
);
  logic [DATAW-1:0] mem_q [NUMREGISTERS];
  function automatic logic [DATAW-1:0] rd(input logic [IW-1:0] x);
`ifdef DECODE_BYPASS_EN
    return (x == '0) ? '0 : (we_i && waddr_i == x) ? wdata_i : mem_q[x];
`else
    return (x == '0) ? '0 : mem_q[x];
`endif
  endfunction
  assign rdata0_o = rd(raddr0_i);
  assign rdata1_o = rd(raddr1_i);
  // Write port; register 0 is never written so it stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUMREGISTERS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined decoder with scoreboard hazard stall; DECODE_BYPASS_EN enables write-back forwarding
module decode_stage import decode_pkg::*; #(
  parameter int NUMREGISTERS = 8,
  parameter int DATAW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instr,
  input  logic             wb_en,
  input  logic [2:0]       wb_reg,
  input  logic [DATAW-1:0] wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] a,
  output logic [DATAW-1:0] b,
  output logic [DATAW-1:0] imm,
  output logic [1:0]       shift_dist,
  output logic [2:0]       dst_reg,
  output logic             alu_op,
  output logic             reg_wr_en,
  output logic             mem_wr_en,
  output logic             branch,
  output logic             fft_wr_en,
  output logic             set_en,
  output logic             syn,
  output logic             use_imm,
  output logic             set_freq,
  output logic             halt,
  output logic             illegal
);
  localparam int IW = (NUMREGISTERS > 1) ? $clog2(NUMREGISTERS) : 1;
  localparam logic [NUMREGISTERS-1:0] ONE = NUMREGISTERS'(1);
  logic [IW-1:0] rd_idx, rs_idx, rt_idx, wb_idx;
  logic [DATAW-1:0] ra, rb;
  logic [10:0] imm11;
  logic [NUMREGISTERS-1:0] wbhit, busy, pending_q, pending_d;
  logic use_rs, use_rt, use_rd, bad, hazard, fire;
  logic out_valid_q, halted_q, illegal_q;
  logic [DATAW-1:0] a_q, b_q, imm_q;
  logic [1:0] shift_q;
  logic [2:0] dst_q;
  ctrl_t c, ctrl_q;
  assign rd_idx = instr[RD_LSB +: IW];
  assign rs_idx = instr[RS_LSB +: IW];
  assign rt_idx = instr[RT_LSB +: IW];
  assign wb_idx = wb_reg[IW-1:0];
  // Opcode decode into control bits and the set of registers read
  always_comb begin
    c = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    use_rd = 1'b0;
    bad = 1'b0;
    case (opcode_e'(instr[OP_LSB +: 5]))
      OP_NOP:  ;
      OP_HALT: c.halt = 1'b1;
      OP_ADD:  begin c.reg_wr_en = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_SUB:  begin c.alu_op = 1'b1; c.reg_wr_en = 1'b1; use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI: begin c.reg_wr_en = 1'b1; c.use_imm = 1'b1; use_rs = 1'b1; end
      OP_ST:   begin c.mem_wr_en = 1'b1; use_rs = 1'b1; use_rd = 1'b1; end
      OP_BR:   c.branch = 1'b1;
      OP_FFT:  begin c.fft_wr_en = 1'b1; use_rs = 1'b1; end
      OP_SET:  c.set_en = 1'b1;
      OP_SYN:  c.syn = 1'b1;
      OP_FREQ: begin c.set_freq = 1'b1; use_rs = 1'b1; end
      default: bad = 1'b1;
    endcase
  end
  assign imm11 = c.use_imm ? sext(instr[10:0], 1'b1) : c.branch ? instr[10:0] : '0;
  decode_regfile #(.NUMREGISTERS(NUMREGISTERS), .DATAW(DATAW)) u_rf (
    .clk(clk), .rst_n(rst_n), .we_i(wb_en), .waddr_i(wb_idx), .wdata_i(wb_data),
    .raddr0_i(rs_idx), .raddr1_i(use_rd ? rd_idx : rt_idx), .rdata0_o(ra), .rdata1_o(rb)
  );
  assign wbhit = (wb_en && wb_idx != '0) ? ONE << wb_idx : '0;
`ifdef DECODE_BYPASS_EN
  assign busy = pending_q & ~wbhit;
`else
  assign busy = pending_q | wbhit;
`endif
  assign hazard = (use_rs & busy[rs_idx]) | (use_rt & busy[rt_idx]) | (use_rd & busy[rd_idx]) |
                  (c.reg_wr_en & pending_q[rd_idx]);
  assign in_ready = (!out_valid_q | out_ready) & !hazard & !halted_q & rst_n;
  assign fire = in_valid & in_ready;
  // Issue sets the destination after write-back clears, so set wins on a collision
  assign pending_d = (pending_q & ~wbhit) | ((fire && c.reg_wr_en && rd_idx != '0) ? ONE << rd_idx : '0);
  // Output bundle, scoreboard and sticky status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      imm_q <= '0;
      shift_q <= '0;
      dst_q <= '0;
      ctrl_q <= '0;
      pending_q <= '0;
      halted_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      if (fire) begin
        out_valid_q <= 1'b1;
        a_q <= ra;
        b_q <= rb;
        imm_q <= {{(DATAW-11){imm11[10]}}, imm11};
        shift_q <= instr[1:0];
        dst_q <= instr[10:8];
        ctrl_q <= c;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      pending_q <= pending_d;
      if (fire && c.halt) halted_q <= 1'b1;
      if (fire && bad) illegal_q <= 1'b1;
    end
  end
  assign out_valid = out_valid_q;
  assign a = a_q;
  assign b = b_q;
  assign imm = imm_q;
  assign shift_dist = shift_q;
  assign dst_reg = dst_q;
  assign {alu_op, reg_wr_en, mem_wr_en, branch, fft_wr_en, set_en, syn, use_imm, set_freq, halt} = ctrl_q;
  assign illegal = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for decode_stage (expectations follow DECODE_BYPASS_EN)
module tb_decode_stage;
  logic clk = 0, rst_n = 0, in_valid = 0, wb_en = 0, out_ready = 1;
  logic in_ready, out_valid, illegal;
  logic [15:0] instr = '0;
  logic [2:0] wb_reg = '0, dst_reg;
  logic [31:0] wb_data = '0, a, b, imm;
  logic [1:0] shift_dist;
  logic alu_op, reg_wr_en, mem_wr_en, branch, fft_wr_en, set_en, syn, use_imm, set_freq, halt;
  int tests = 0, fails = 0;
  logic [110:0] q[$];
  logic [110:0] held;

  always #5 clk = ~clk;

  decode_stage #(.NUMREGISTERS(8), .DATAW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .imm(imm), .shift_dist(shift_dist), .dst_reg(dst_reg),
    .alu_op(alu_op), .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .branch(branch),
    .fft_wr_en(fft_wr_en), .set_en(set_en), .syn(syn), .use_imm(use_imm),
    .set_freq(set_freq), .halt(halt), .illegal(illegal)
  );

  function automatic logic [110:0] mk(input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ei,
                                      input logic [2:0] d, input logic [1:0] s, input logic [9:0] c);
    return {ea, eb, ei, d, s, c};
  endfunction

  function automatic logic [110:0] obs();
    return {a, b, imm, dst_reg, shift_dist, alu_op, reg_wr_en, mem_wr_en, branch, fft_wr_en,
            set_en, syn, use_imm, set_freq, halt};
  endfunction

  task automatic check(input string tag, input logic [110:0] o, input logic [110:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    if (q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s observed=bundle expected=none-queued", tag);
    end else begin
      check(tag, obs(), q.pop_front());
    end
  endtask

  task automatic issue(input string tag, input logic [15:0] ins, input logic [110:0] e);
    in_valid = 1;
    instr = ins;
    #1;
    check({tag, " rdy"}, 111'(in_ready), 111'(1));
    q.push_back(e);
    step();
    in_valid = 0;
    check({tag, " vld"}, 111'(out_valid), 111'(1));
    pop_chk(tag);
  endtask

  initial begin
    step();
    step();
    check("rst vld", 111'(out_valid), 0);
    check("rst ill", 111'(illegal), 0);
    check("rst rdy", 111'(in_ready), 0);
    check("rst bundle", obs(), 0);
    rst_n = 1;
    #1 check("idle rdy", 111'(in_ready), 111'(1));
    wb_en = 1; wb_reg = 3; wb_data = 32'h1234;
    step();
    wb_en = 0;
    issue("add", 16'h1160, mk(32'h1234, 0, 0, 1, 0, 10'h100));
    issue("addi", 16'h221D, mk(0, 0, 32'hFFFFFFFD, 2, 1, 10'h104));
    in_valid = 1; instr = 16'h1440;
    #1 check("raw stall0", 111'(in_ready), 0);
    step();
    check("raw drain", 111'(out_valid), 0);
    check("raw stall1", 111'(in_ready), 0);
    wb_en = 1; wb_reg = 2; wb_data = 32'd7;
    #1;
`ifdef DECODE_BYPASS_EN
    check("raw byp rdy", 111'(in_ready), 111'(1));
    q.push_back(mk(32'd7, 0, 0, 4, 0, 10'h100));
    step();
    wb_en = 0; in_valid = 0;
    check("raw byp vld", 111'(out_valid), 111'(1));
    pop_chk("raw byp");
`else
    check("raw wb stall", 111'(in_ready), 0);
    step();
    wb_en = 0;
    check("raw nobyp drain", 111'(out_valid), 0);
    issue("raw nobyp", 16'h1440, mk(32'd7, 0, 0, 4, 0, 10'h100));
`endif
    issue("sub", 16'h1D6E, mk(32'h1234, 32'h1234, 0, 5, 2, 10'h300));
    held = obs();
    out_ready = 0; in_valid = 1; instr = 16'h2B60;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp rdy", 111'(in_ready), 0);
      step();
      check("bp vld", 111'(out_valid), 111'(1));
      check("bp hold", obs(), held);
    end
    out_ready = 1;
    issue("st", 16'h2B60, mk(32'h1234, 32'h1234, 0, 3, 0, 10'h080));
    step();
    check("no dup", 111'(out_valid), 0);
    issue("ill", 16'hF800, mk(0, 0, 0, 0, 0, 10'h000));
    check("ill set", 111'(illegal), 111'(1));
    wb_en = 1; wb_reg = 0; wb_data = 32'hDEAD;
    issue("freq r0 wb", 16'h5000, mk(0, 0, 0, 0, 0, 10'h002));
    wb_en = 0;
    issue("freq r0", 16'h5000, mk(0, 0, 0, 0, 0, 10'h002));
    issue("br", 16'h37FF, mk(0, 0, 32'hFFFFFFFF, 7, 3, 10'h040));
    check("ill sticky", 111'(illegal), 111'(1));
    issue("halt", 16'h0B6F, mk(32'h1234, 32'h1234, 0, 3, 3, 10'h001));
    held = obs();
    out_ready = 0; in_valid = 1; instr = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      #1 check("halt hold rdy", 111'(in_ready), 0);
      step();
      check("halt hold", obs(), held);
    end
    out_ready = 1;
    #1 check("halted rdy0", 111'(in_ready), 0);
    step();
    check("halt once", 111'(out_valid), 0);
    check("halted rdy1", 111'(in_ready), 0);
    step();
    check("halted rdy2", 111'(in_ready), 0);
    #2 rst_n = 0;
    #1;
    check("arst bundle", obs(), 0);
    check("arst vld", 111'(out_valid), 0);
    check("arst ill", 111'(illegal), 0);
    check("arst rdy", 111'(in_ready), 0);
    step();
    rst_n = 1;
    #1 check("post rst rdy", 111'(in_ready), 111'(1));
    in_valid = 0;
    issue("post rst add", 16'h1160, mk(0, 0, 0, 1, 0, 10'h100));
    check("queue empty", 111'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
